// File: rtl/regfile_ctrl_pkg.sv
// Shared defaults and grant encoding for the register-file writeback arbiter.
package regfile_ctrl_pkg;

  localparam int ADDRESS_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF    = 32;
  localparam int STARVE_LIMIT_DEF  = 4;
  localparam int STARVE_CNT_W      = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_P    = 2'd1,
    GNT_M    = 2'd2
  } grant_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy bits for outstanding multi-cycle results.
// A set and a clear of the same register in one cycle leaves the bit set.
module wb_scoreboard
  import regfile_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_valid,
  input  logic [ADDRESS_WIDTH-1:0] set_rd,
  input  logic                     clr_valid,
  input  logic [ADDRESS_WIDTH-1:0] clr_rd,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  output logic                     rs1_busy,
  output logic                     rs2_busy
);

  localparam int NREG = 1 << ADDRESS_WIDTH;

  logic [NREG-1:0] busy;

  // Set is applied after clear so it wins; x0 can never become busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (clr_valid) busy[clr_rd] <= 1'b0;
      if (set_valid && (set_rd != '0)) busy[set_rd] <= 1'b1;
    end
  end

  // Re-issuing to a busy register is illegal unless it retires this same cycle.
  always_ff @(posedge clk) begin
    if (rst_n && set_valid && (set_rd != '0)) begin
      assert (!busy[set_rd] || (clr_valid && (clr_rd == set_rd)));
    end
  end

  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates pipeline (P) and multi-cycle (M) writebacks onto one register-file
// write port. Optional scoreboard enabled by macro REGFILE_WB_SCOREBOARD_EN.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int STARVE_LIMIT  = STARVE_LIMIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     p_valid,
  output logic                     p_ready,
  input  logic [ADDRESS_WIDTH-1:0] p_rd,
  input  logic [DATA_WIDTH-1:0]    p_data,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic [ADDRESS_WIDTH-1:0] m_rd,
  input  logic [DATA_WIDTH-1:0]    m_data,
  input  logic                     iss_valid,
  input  logic [ADDRESS_WIDTH-1:0] iss_rd,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic                     WE3,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0]    WD3
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  // Handshake: a port transfers in any cycle where its valid and ready are both
  // high; the requester holds valid/rd/data stable until then. ready is a
  // combinational function of both valids and starve_cnt, and is never high
  // without the matching valid, so ready alone marks a transfer.
  grant_t                  gnt;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    starve_hit;
  logic                    p_xfer;
  logic                    m_xfer;
  logic                    sb_rs1_busy;
  logic                    sb_rs2_busy;
  logic                    rs1_in_flight;
  logic                    rs2_in_flight;

  assign starve_hit = (starve_cnt == LIMIT);

  always_comb begin
    gnt = GNT_NONE;
    if (rst_n) begin
      if (p_valid && m_valid) gnt = starve_hit ? GNT_M : GNT_P;
      else if (p_valid)       gnt = GNT_P;
      else if (m_valid)       gnt = GNT_M;
    end
  end

  assign p_ready = (gnt == GNT_P);
  assign m_ready = (gnt == GNT_M);
  assign p_xfer  = p_valid && p_ready;
  assign m_xfer  = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (m_xfer) begin
      starve_cnt <= '0;
    end else if (m_valid && !starve_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      WE3 <= 1'b0;
      AD3 <= '0;
      WD3 <= '0;
    end else if (p_xfer) begin
      WE3 <= (p_rd != '0);
      AD3 <= p_rd;
      WD3 <= p_data;
    end else if (m_xfer) begin
      WE3 <= (m_rd != '0);
      AD3 <= m_rd;
      WD3 <= m_data;
    end else begin
      WE3 <= 1'b0;
    end
  end

  assign rs1_in_flight = WE3 && (AD3 == rs1) && (rs1 != '0);
  assign rs2_in_flight = WE3 && (AD3 == rs2) && (rs2 != '0);

`ifdef REGFILE_WB_SCOREBOARD_EN
  wb_scoreboard #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_valid(iss_valid),
    .set_rd   (iss_rd),
    .clr_valid(m_xfer),
    .clr_rd   (m_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (sb_rs1_busy),
    .rs2_busy (sb_rs2_busy)
  );
`else
  logic unused_iss;
  assign unused_iss  = ^{iss_valid, iss_rd};
  assign sb_rs1_busy = 1'b0;
  assign sb_rs2_busy = 1'b0;
`endif

  assign rs1_busy = sb_rs1_busy || rs1_in_flight;
  assign rs2_busy = sb_rs2_busy || rs2_in_flight;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus hand-written
// contention, scoreboard and mid-operation reset sequences.
module tb_regfile_wb_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int WB_W = 1 + AW + DW;
`ifdef REGFILE_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          p_valid, p_ready;
  logic [AW-1:0] p_rd;
  logic [DW-1:0] p_data;
  logic          m_valid, m_ready;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic [AW-1:0] rs1, rs2;
  logic          rs1_busy, rs2_busy;
  logic          WE3;
  logic [AW-1:0] AD3;
  logic [DW-1:0] WD3;

  regfile_wb_arbiter #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p_valid  (p_valid),
    .p_ready  (p_ready),
    .p_rd     (p_rd),
    .p_data   (p_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_rd     (m_rd),
    .m_data   (m_data),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .WE3      (WE3),
    .AD3      (AD3),
    .WD3      (WD3)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int total = 0;
  int bad   = 0;
  logic [WB_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic pv, input logic [AW-1:0] prd, input logic [DW-1:0] pd,
                       input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                       input logic iv, input logic [AW-1:0] ird,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    p_valid = pv;  p_rd = prd;  p_data = pd;
    m_valid = mv;  m_rd = mrd;  m_data = md;
    iss_valid = iv; iss_rd = ird;
    rs1 = r1; rs2 = r2;
  endtask

  task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, r1, r2);
  endtask

  // Inputs already driven just after a rising edge: check readies, clock once,
  // then check the registered write port and busy lookups.
  task automatic step(input string name, input logic epr, input logic emr,
                      input logic ewe, input logic [AW-1:0] ead, input logic [DW-1:0] ewd,
                      input logic chk_adwd, input logic eb1, input logic eb2);
    logic [WB_W-1:0] e;
    #1;
    check({name, ".p_ready"}, 64'(p_ready), 64'(epr));
    check({name, ".m_ready"}, 64'(m_ready), 64'(emr));
    exp_q.push_back({ewe, ead, ewd});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s.queue: got empty expected entry", name);
    end else begin
      e = exp_q.pop_front();
      check({name, ".WE3"}, 64'(WE3), 64'(e[WB_W-1]));
      if (chk_adwd) begin
        check({name, ".AD3"}, 64'(AD3), 64'(e[WB_W-2 -: AW]));
        check({name, ".WD3"}, 64'(WD3), 64'(e[DW-1:0]));
      end
    end
    check({name, ".rs1_busy"}, 64'(rs1_busy), 64'(eb1));
    check({name, ".rs2_busy"}, 64'(rs2_busy), 64'(eb2));
  endtask

  typedef struct {
    logic          pv;
    logic [AW-1:0] prd;
    logic [DW-1:0] pd;
    logic          mv;
    logic [AW-1:0] mrd;
    logic [DW-1:0] md;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic          epr;
    logic          emr;
    logic          ewe;
    logic [AW-1:0] ead;
    logic [DW-1:0] ewd;
    logic          chk;
    logic          eb1;
    logic          eb2;
  } vec_t;

  vec_t vecs[9];

  initial begin
    //            pv prd  pd            mv mrd  md            r1  r2  epr emr ewe ead  ewd           chk eb1 eb2
    vecs[0] = '{1, 5,  32'hDEADBEEF, 0, 0,  0,            5,  4,  1,  0,  1,  5,  32'hDEADBEEF, 1,  1,  0};
    vecs[1] = '{0, 0,  0,            0, 0,  0,            5,  5,  0,  0,  0,  5,  32'hDEADBEEF, 1,  0,  0};
    vecs[2] = '{0, 0,  0,            1, 12, 32'hCAFE0001, 12, 0,  0,  1,  1,  12, 32'hCAFE0001, 1,  1,  0};
    vecs[3] = '{1, 0,  32'h00001234, 0, 0,  0,            0,  12, 1,  0,  0,  0,  0,            0,  0,  0};
    vecs[4] = '{0, 0,  0,            1, 0,  32'h00000055, 0,  0,  0,  1,  0,  0,  0,            0,  0,  0};
    vecs[5] = '{1, 31, 32'hFFFFFFFF, 0, 0,  0,            31, 31, 1,  0,  1,  31, 32'hFFFFFFFF, 1,  1,  1};
    vecs[6] = '{0, 0,  0,            0, 0,  0,            31, 0,  0,  0,  0,  31, 32'hFFFFFFFF, 1,  0,  0};
    vecs[7] = '{1, 10, 32'h0000000A, 1, 11, 32'h0000000B, 10, 11, 1,  0,  1,  10, 32'h0000000A, 1,  1,  0};
    vecs[8] = '{0, 0,  0,            1, 11, 32'h0000000B, 11, 10, 0,  1,  1,  11, 32'h0000000B, 1,  1,  0};

    // Reset with a request pending: no ready, outputs cleared
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 32'h11111111, 1'b1, 5'd6, 32'h22222222, 1'b0, '0, '0, '0);
    @(posedge clk);
    #1;
    step("reset0", 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    idle('0, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].pv, vecs[i].prd, vecs[i].pd, vecs[i].mv, vecs[i].mrd, vecs[i].md,
            1'b0, '0, vecs[i].r1, vecs[i].r2);
      step($sformatf("vec%0d", i), vecs[i].epr, vecs[i].emr, vecs[i].ewe, vecs[i].ead,
           vecs[i].ewd, vecs[i].chk, vecs[i].eb1, vecs[i].eb2);
    end

    // Continuous contention: four P wins, then forced M win, repeating
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'd2, 32'hAAAA0000, 1'b1, 5'd3, 32'hBBBB0000, 1'b0, '0, '0, '0);
      if ((i % 5) == 4)
        step($sformatf("cont%0d", i), 1'b0, 1'b1, 1'b1, 5'd3, 32'hBBBB0000, 1'b1, 1'b0, 1'b0);
      else
        step($sformatf("cont%0d", i), 1'b1, 1'b0, 1'b1, 5'd2, 32'hAAAA0000, 1'b1, 1'b0, 1'b0);
    end
    idle('0, '0);
    step("cont_idle", 1'b0, 1'b0, 1'b0, 5'd3, 32'hBBBB0000, 1'b1, 1'b0, 1'b0);

    // Issue x7, then retire it through M: busy, then in flight, then free
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd7);
    step("iss7", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, SB, SB);
    idle(5'd7, 5'd0);
    step("iss7_hold", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, SB, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h00000077, 1'b0, '0, 5'd7, 5'd0);
    step("ret7", 1'b0, 1'b1, 1'b1, 5'd7, 32'h00000077, 1'b1, 1'b1, 1'b0);
    idle(5'd7, 5'd0);
    step("ret7_done", 1'b0, 1'b0, 1'b0, 5'd7, 32'h00000077, 1'b1, 1'b0, 1'b0);

    // Same-cycle issue and retire of x9 keeps it busy
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
    step("iss9", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, SB, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 5'd9, 32'h00000099, 1'b1, 5'd9, 5'd9, 5'd0);
    step("iss_ret9", 1'b0, 1'b1, 1'b1, 5'd9, 32'h00000099, 1'b1, 1'b1, 1'b0);
    idle(5'd9, 5'd0);
    step("iss_ret9_after", 1'b0, 1'b0, 1'b0, 5'd9, 32'h00000099, 1'b1, SB, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 5'd9, 32'h00000098, 1'b0, '0, 5'd9, 5'd0);
    step("ret9", 1'b0, 1'b1, 1'b1, 5'd9, 32'h00000098, 1'b1, 1'b1, 1'b0);
    idle(5'd9, 5'd0);
    step("ret9_done", 1'b0, 1'b0, 1'b0, 5'd9, 32'h00000098, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd0, 5'd0, 5'd0);
    step("iss0", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Reset mid-contention with x3 busy
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd0);
    step("iss3", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, SB, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'd2, 32'hAAAA0000, 1'b1, 5'd3, 32'hBBBB0000, 1'b0, '0, 5'd3, 5'd0);
      step($sformatf("pre_rst%0d", i), 1'b1, 1'b0, 1'b1, 5'd2, 32'hAAAA0000, 1'b1, SB, 1'b0);
    end
    rst_n = 1'b0;
    step("mid_rst0", 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step("mid_rst1", 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    check("post_rst.WE3", 64'(WE3), 64'd0);
    check("post_rst.rs1_busy", 64'(rs1_busy), 64'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4)
        step($sformatf("post_rst%0d", i), 1'b0, 1'b1, 1'b1, 5'd3, 32'hBBBB0000, 1'b1, 1'b1, 1'b0);
      else
        step($sformatf("post_rst%0d", i), 1'b1, 1'b0, 1'b1, 5'd2, 32'hAAAA0000, 1'b1, 1'b0, 1'b0);
    end
    idle('0, '0);
    @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 5, register address width.
REQ-002 Parameter DATA_WIDTH, default 32, register data width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive M-port losses before M gets forced priority (range 1..15).
REQ-004 Ports SHALL be, in order:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- p_valid / p_ready  in / out  1 / 1  pipeline writeback request handshake.
- p_rd / p_data  in / in  ADDRESS_WIDTH / DATA_WIDTH  pipeline destination register and value.
- m_valid / m_ready  in / out  1 / 1  multi-cycle unit writeback request handshake.
- m_rd / m_data  in / in  ADDRESS_WIDTH / DATA_WIDTH  multi-cycle destination register and value.
- iss_valid / iss_rd  in / in  1 / ADDRESS_WIDTH  multi-cycle op issued; iss_rd becomes busy.
- rs1 / rs2  in / in  ADDRESS_WIDTH each  decode-stage source addresses.
- rs1_busy / rs2_busy  out / out  1 each  source not yet safely readable.
- WE3 / AD3 / WD3  out / out / out  1 / ADDRESS_WIDTH / DATA_WIDTH  register file write port.

Function
REQ-005 Transfer on a port SHALL occur in a cycle where valid and ready are both high; requesters SHALL hold valid, rd and data stable until transfer.
REQ-006 ready outputs SHALL be combinational: only one valid -> that port ready; both valid -> P ready unless starve_cnt == STARVE_LIMIT, then M ready; the loser's ready SHALL be low.
REQ-007 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle m_valid is high without M transfer, and clear to 0 on M transfer.
REQ-008 Write path SHALL be registered, latency 1: cycle after a transfer, WE3 = 1, AD3 = rd, WD3 = data of winner; cycle after no transfer, WE3 = 0 and AD3/WD3 hold.
REQ-009 Transfer with rd == 0 SHALL be accepted (ready high) but produce WE3 = 0.
REQ-010 Scoreboard: busy[iss_rd] SHALL set on iss_valid when iss_rd != 0; busy[m_rd] SHALL clear on M transfer; busy[0] SHALL be constant 0.
REQ-011 Simultaneous set and clear of the same register SHALL leave it set.
REQ-012 rsN_busy SHALL be high when busy[rsN] is set, or when WE3 is high and AD3 == rsN != 0 (write in flight).
REQ-013 iss_valid to an already-busy register SHALL be a protocol violation, flagged by simulation assertion; the bit stays set.

Reset
REQ-014 While rst_n is low at a clock edge: WE3, AD3, WD3, starve_cnt and all busy bits SHALL be 0.
REQ-015 While rst_n is low, p_ready and m_ready SHALL be 0 and no transfer SHALL occur.
REQ-016 Reset asserted mid-operation SHALL discard pending requests and scoreboard state with no residual write on the cycle after release.

Configuration
REQ-017 Macro REGFILE_WB_SCOREBOARD_EN defined: REQ-010..REQ-013 apply. Undefined: scoreboard absent, rs1_busy/rs2_busy driven only by the in-flight term of REQ-012, iss_valid/iss_rd ignored.

Structure
REQ-018 Package regfile_ctrl_pkg SHALL hold ADDRESS_WIDTH/DATA_WIDTH defaults, the grant enum (GNT_NONE, GNT_P, GNT_M) and the STARVE_LIMIT default.
REQ-019 Scoreboard SHALL be a sub-module wb_scoreboard (set/clear/two lookups), instantiated only under REGFILE_WB_SCOREBOARD_EN.

Verification
REQ-020 P only: p_valid=1, p_rd=5, p_data=0xDEADBEEF -> p_ready=1 same cycle; next cycle WE3=1, AD3=5, WD3=0xDEADBEEF.
REQ-021 Contention: P and M valid continuously, STARVE_LIMIT=4 -> P wins 4 cycles, M wins cycle 5, starve_cnt returns to 0, P wins again.
REQ-022 x0: p_rd=0, p_data=0x1234 -> p_ready=1, WE3 stays 0 next cycle.
REQ-023 Scoreboard: iss_valid, iss_rd=7; rs1=7 -> rs1_busy=1; M transfer m_rd=7 -> rs1_busy stays 1 one more cycle (in flight), then 0.
REQ-024 Same-cycle iss_rd=9 and M transfer m_rd=9 -> busy[9] remains 1.
REQ-025 Reset mid-contention with busy[3] set -> after release, WE3=0, rs busy for 3 = 0, starve_cnt=0, both ready follow REQ-006.
